// File: rtl/kbd_bcd_calc.sv
// Keyboard-driven BCD calculator core.
// Collects two DIGITS-wide BCD operands from decoded PS/2 make codes, computes A+B or A-B
// one digit per cycle and drives a multiplexed single-digit scan for a 7-segment decoder.
// Optional build macro: LEADING_BLANK_EN blanks displayed positions above the most
// significant non-zero digit (position 0 is always shown, the minus sign always wins).
module kbd_bcd_calc #(
  parameter int unsigned DIGITS      = 2,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [8:0]              last_change,
  input  logic                    key_press,
  output logic [1:0]              state,
  output logic                    op_sub,
  output logic                    result_valid,
  output logic [4*(DIGITS+1)-1:0] disp_bcd,
  output logic                    disp_neg,
  output logic [3:0]              scan_digit,
  output logic [DIGITS:0]         ssd_ctrl
);

  localparam int unsigned NDisp = DIGITS + 1;
  localparam int unsigned OpW   = 4 * DIGITS;
  localparam int unsigned DispW = 4 * NDisp;
  localparam int unsigned CntW  = $clog2(DIGITS + 1);
  localparam int unsigned DivW  = $clog2(REFRESH_DIV + 1);

  localparam logic [8:0] KeyPlus  = 9'h079;
  localparam logic [8:0] KeyMinus = 9'h07B;
  localparam logic [8:0] KeyEnter = 9'h05A;
  localparam logic [8:0] KeyEsc   = 9'h076;

  typedef enum logic [1:0] {
    StEnterA = 2'd0,
    StEnterB = 2'd1,
    StCalc   = 2'd2,
    StShow   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              key_q;
  logic [OpW-1:0]    a_q, a_d, b_q, b_d;
  logic [CntW-1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [CntW-1:0]   step_q, step_d;
  logic [DispW-1:0]  r_q, r_d;
  logic [DispW-1:0]  hold_q, hold_d;
  logic              op_sub_q, op_sub_d;
  logic              neg_q, neg_d;
  logic              cy_q, cy_d;
  logic              rv_q, rv_d;
  logic [DivW-1:0]   div_q;
  logic [CntW-1:0]   scan_idx_q;

  logic              key_is_digit;
  logic [3:0]        key_digit;
  logic              key_evt;
  logic              ev_digit, ev_plus, ev_minus, ev_op, ev_enter, ev_esc;

  // Digit-serial arithmetic helpers for the current CALC step.
  int unsigned       dig_idx;
  logic [3:0]        a_nib, b_nib, nib;
  logic [4:0]        sum5, dif5;
  logic              cout;

  // Map make codes onto digit values.
  always_comb begin
    key_is_digit = 1'b1;
    key_digit    = 4'd0;
    case (last_change)
      9'h045:  key_digit = 4'd0;
      9'h016:  key_digit = 4'd1;
      9'h01E:  key_digit = 4'd2;
      9'h026:  key_digit = 4'd3;
      9'h025:  key_digit = 4'd4;
      9'h02E:  key_digit = 4'd5;
      9'h036:  key_digit = 4'd6;
      9'h03D:  key_digit = 4'd7;
      9'h03E:  key_digit = 4'd8;
      9'h046:  key_digit = 4'd9;
      default: key_is_digit = 1'b0;
    endcase
  end

  // One event per press: rising edge of the held-key level.
  assign key_evt  = key_press & ~key_q;
  assign ev_digit = key_evt & key_is_digit;
  assign ev_plus  = key_evt & (last_change == KeyPlus);
  assign ev_minus = key_evt & (last_change == KeyMinus);
  assign ev_op    = ev_plus | ev_minus;
  assign ev_enter = key_evt & (last_change == KeyEnter);
  assign ev_esc   = key_evt & (last_change == KeyEsc);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StEnterA;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    if (ev_esc) begin
      state_d = StEnterA;
    end else begin
      case (state_q)
        StEnterA: if (ev_op) state_d = StEnterB;
        StEnterB: if (ev_enter) state_d = StCalc;
        StCalc:   if (step_q == CntW'(DIGITS)) state_d = StShow;
        StShow:   if (ev_digit) state_d = StEnterA;
        default:  state_d = StEnterA;
      endcase
    end
  end

  // Operand entry and digit-serial add/subtract datapath.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    step_d   = step_q;
    r_d      = r_q;
    op_sub_d = op_sub_q;
    neg_d    = neg_q;
    cy_d     = cy_q;
    rv_d     = 1'b0;
    hold_d   = (state_q == StCalc) ? hold_q : disp_bcd;

    dig_idx  = (step_q == '0) ? 0 : int'(step_q) - 1;
    a_nib    = a_q[4*dig_idx +: 4];
    b_nib    = b_q[4*dig_idx +: 4];
    sum5     = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, cy_q};
    dif5     = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0, cy_q};
    if (op_sub_q) begin
      cout = dif5[4];
      nib  = dif5[4] ? (dif5[3:0] + 4'd10) : dif5[3:0];
    end else begin
      cout = (sum5 > 5'd9);
      nib  = (sum5 > 5'd9) ? (sum5[3:0] + 4'd6) : sum5[3:0];
    end

    if (ev_esc) begin
      a_d      = '0;
      b_d      = '0;
      cnt_a_d  = '0;
      cnt_b_d  = '0;
      step_d   = '0;
      r_d      = '0;
      op_sub_d = 1'b0;
      neg_d    = 1'b0;
      cy_d     = 1'b0;
    end else begin
      case (state_q)
        StEnterA: begin
          if (ev_digit && (cnt_a_q < CntW'(DIGITS))) begin
            a_d     = (a_q << 4) | OpW'(key_digit);
            cnt_a_d = cnt_a_q + CntW'(1);
          end
          if (ev_op) op_sub_d = ev_minus;
        end
        StEnterB: begin
          if (ev_digit && (cnt_b_q < CntW'(DIGITS))) begin
            b_d     = (b_q << 4) | OpW'(key_digit);
            cnt_b_d = cnt_b_q + CntW'(1);
          end
          if (ev_op) op_sub_d = ev_minus;
          if (ev_enter) begin
            step_d = '0;
            cy_d   = 1'b0;
          end
        end
        StCalc: begin
          if (step_q == '0) begin
            // Subtract always runs larger-minus-smaller; the sign is kept separately.
            neg_d = op_sub_q & (a_q < b_q);
            if (op_sub_q && (a_q < b_q)) begin
              a_d = b_q;
              b_d = a_q;
            end
            cy_d   = 1'b0;
            step_d = CntW'(1);
          end else begin
            r_d[4*dig_idx +: 4] = nib;
            cy_d = cout;
            if (step_q == CntW'(DIGITS)) begin
              r_d[4*DIGITS +: 4] = op_sub_q ? 4'd0 : {3'b0, cout};
              rv_d   = 1'b1;
              step_d = '0;
            end else begin
              step_d = step_q + CntW'(1);
            end
          end
        end
        StShow: begin
          if (ev_digit) begin
            a_d     = OpW'(key_digit);
            cnt_a_d = CntW'(1);
            b_d     = '0;
            cnt_b_d = '0;
            neg_d   = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and key-edge registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      key_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      step_q   <= '0;
      r_q      <= '0;
      hold_q   <= '0;
      op_sub_q <= 1'b0;
      neg_q    <= 1'b0;
      cy_q     <= 1'b0;
      rv_q     <= 1'b0;
    end else begin
      key_q    <= key_press;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      step_q   <= step_d;
      r_q      <= r_d;
      hold_q   <= hold_d;
      op_sub_q <= op_sub_d;
      neg_q    <= neg_d;
      cy_q     <= cy_d;
      rv_q     <= rv_d;
    end
  end

  // Display scan divider and position index; Esc leaves these running.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q      <= '0;
      scan_idx_q <= '0;
    end else if (div_q == DivW'(REFRESH_DIV - 1)) begin
      div_q      <= '0;
      scan_idx_q <= (scan_idx_q == CntW'(DIGITS)) ? '0 : scan_idx_q + CntW'(1);
    end else begin
      div_q <= div_q + DivW'(1);
    end
  end

`ifdef LEADING_BLANK_EN
  logic [CntW-1:0] msd_idx;
`endif

  // Outputs: displayed value, sign, and the scanned digit.
  always_comb begin
    state        = state_q;
    op_sub       = op_sub_q;
    result_valid = rv_q;
    disp_bcd     = '0;
    case (state_q)
      StEnterA: disp_bcd = DispW'(a_q);
      StEnterB: disp_bcd = DispW'(b_q);
      StCalc:   disp_bcd = hold_q;
      StShow:   disp_bcd = r_q;
      default:  disp_bcd = '0;
    endcase
    disp_neg   = neg_q & (state_q == StShow);
    ssd_ctrl   = ~(NDisp'(1) << scan_idx_q);
    scan_digit = disp_bcd[4*scan_idx_q +: 4];
`ifdef LEADING_BLANK_EN
    msd_idx = '0;
    for (int i = 1; i < int'(NDisp); i++) begin
      if (disp_bcd[4*i +: 4] != 4'd0) msd_idx = CntW'(i);
    end
    if (scan_idx_q > msd_idx) scan_digit = 4'hF;
`endif
    if (disp_neg && (scan_idx_q == CntW'(DIGITS))) scan_digit = 4'hA;
  end

endmodule

// File: tb/tb_kbd_bcd_calc.sv
// Directed bench for kbd_bcd_calc (DIGITS=2, REFRESH_DIV=4) with a decimal reference model.
module tb_kbd_bcd_calc;

  localparam int D  = 2;
  localparam int RD = 4;
  localparam int DW = 4 * (D + 1);

  localparam logic [8:0] K_PLUS  = 9'h079;
  localparam logic [8:0] K_MINUS = 9'h07B;
  localparam logic [8:0] K_ENTER = 9'h05A;
  localparam logic [8:0] K_ESC   = 9'h076;

  logic          clk = 1'b0;
  logic          reset;
  logic [8:0]    last_change;
  logic          key_press;
  logic [1:0]    state;
  logic          op_sub;
  logic          result_valid;
  logic [DW-1:0] disp_bcd;
  logic          disp_neg;
  logic [3:0]    scan_digit;
  logic [D:0]    ssd_ctrl;

  int n_checks = 0;
  int n_errs   = 0;

  kbd_bcd_calc #(.DIGITS(D), .REFRESH_DIV(RD)) dut (
    .clk          (clk),
    .reset        (reset),
    .last_change  (last_change),
    .key_press    (key_press),
    .state        (state),
    .op_sub       (op_sub),
    .result_valid (result_valid),
    .disp_bcd     (disp_bcd),
    .disp_neg     (disp_neg),
    .scan_digit   (scan_digit),
    .ssd_ctrl     (ssd_ctrl)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] digit_code(input int d);
    case (d)
      0: return 9'h045;  1: return 9'h016;  2: return 9'h01E;  3: return 9'h026;
      4: return 9'h025;  5: return 9'h02E;  6: return 9'h036;  7: return 9'h03D;
      8: return 9'h03E;  default: return 9'h046;
    endcase
  endfunction

  function automatic int digit_of(input logic [8:0] c);
    for (int i = 0; i < 10; i++) if (digit_code(i) == c) return i;
    return -1;
  endfunction

  function automatic logic [DW-1:0] to_bcd(input int v);
    logic [DW-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < D + 1; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Reference model: operands and result kept as plain decimal integers.
  int m_state, m_a, m_b, m_na, m_nb, m_r, m_hold, m_cc, m_div, m_idx;
  bit m_op, m_neg, m_rv, m_key_q, model_ok;
  int m_d;
  bit m_evt;

  function automatic int model_disp();
    case (m_state)
      0:       return m_a;
      1:       return m_b;
      2:       return m_hold;
      default: return m_r;
    endcase
  endfunction

  task automatic model_clear();
    m_state = 0; m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_r = 0;
    m_cc = 0; m_op = 0; m_neg = 0; m_rv = 0;
  endtask

  task automatic model_step();
    if (!reset) begin
      model_clear();
      m_hold = 0; m_div = 0; m_idx = 0; m_key_q = 0;
      model_ok = 1;
      return;
    end
    m_evt = key_press && !m_key_q;
    m_key_q = key_press;
    m_d = digit_of(last_change);
    if (m_state != 2) m_hold = model_disp();
    m_rv = 0;
    if (m_evt && last_change == K_ESC) begin
      model_clear();
    end else begin
      case (m_state)
        0: begin
          if (m_evt && m_d >= 0 && m_na < D) begin m_a = m_a * 10 + m_d; m_na++; end
          if (m_evt && (last_change == K_PLUS || last_change == K_MINUS)) begin
            m_op = (last_change == K_MINUS);
            m_state = 1;
          end
        end
        1: begin
          if (m_evt && m_d >= 0 && m_nb < D) begin m_b = m_b * 10 + m_d; m_nb++; end
          if (m_evt && (last_change == K_PLUS || last_change == K_MINUS))
            m_op = (last_change == K_MINUS);
          if (m_evt && last_change == K_ENTER) begin m_state = 2; m_cc = 0; end
        end
        2: begin
          m_cc++;
          if (m_cc == D + 1) begin
            m_state = 3;
            m_rv = 1;
            if (m_op) begin
              m_neg = (m_a < m_b);
              m_r = m_neg ? (m_b - m_a) : (m_a - m_b);
            end else begin
              m_neg = 0;
              m_r = m_a + m_b;
            end
          end
        end
        default: begin
          if (m_evt && m_d >= 0) begin
            m_a = m_d; m_na = 1; m_b = 0; m_nb = 0; m_neg = 0; m_state = 0;
          end
        end
      endcase
    end
    if (m_div == RD - 1) begin
      m_div = 0;
      m_idx = (m_idx == D) ? 0 : m_idx + 1;
    end else begin
      m_div++;
    end
  endtask

  task automatic model_compare();
    int dv;
    bit dneg;
    logic [DW-1:0] bcd;
    logic [3:0] sd;
    logic [D:0] en;
`ifdef LEADING_BLANK_EN
    int lim;
`endif
    dv   = model_disp();
    dneg = m_neg && (m_state == 3);
    bcd  = to_bcd(dv);
    sd   = bcd[4*m_idx +: 4];
`ifdef LEADING_BLANK_EN
    lim = 1;
    for (int i = 0; i < m_idx; i++) lim = lim * 10;
    if (m_idx > 0 && dv < lim) sd = 4'hF;
`endif
    if (dneg && m_idx == D) sd = 4'hA;
    for (int p = 0; p <= D; p++) en[p] = (p != m_idx);
    check("m_state", state, m_state);
    check("m_op_sub", op_sub, m_op);
    check("m_result_valid", result_valid, m_rv);
    check("m_disp_bcd", disp_bcd, bcd);
    check("m_disp_neg", disp_neg, dneg);
    check("m_ssd_ctrl", ssd_ctrl, en);
    check("m_scan_digit", scan_digit, sd);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (model_ok) model_compare();
  end

  task automatic press(input logic [8:0] code, input int hold);
    @(posedge clk); #1;
    last_change = code;
    key_press = 1'b1;
    repeat (hold) @(posedge clk);
    #1 key_press = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [8:0] code);
    press(code, 2);
  endtask

  task automatic num(input int d);
    press(digit_code(d), 2);
  endtask

  // Enter key with an explicit check of the result_valid latency.
  task automatic enter_timed(input string name);
    @(posedge clk); #1;
    last_change = K_ENTER;
    key_press = 1'b1;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1 check({name, "_rv_early"}, result_valid, 1'b0);
    @(posedge clk);
    #1 check({name, "_rv_latency"}, result_valid, 1'b1);
    key_press = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_scan(input logic [D:0] pat, input string name);
    bit found;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk); #1;
      if (ssd_ctrl == pat) found = 1;
    end
    check({name, "_reached"}, found, 1'b1);
  endtask

  initial begin
    reset = 1'b0;
    key_press = 1'b0;
    last_change = 9'h000;
    model_ok = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", state, 2'd0);
    check("rst_disp", disp_bcd, 12'h000);
    check("rst_ssd", ssd_ctrl, 3'b110);
    check("rst_rv", result_valid, 1'b0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("scan_0", ssd_ctrl, 3'b110);
    @(posedge clk);
    #1 check("scan_1", ssd_ctrl, 3'b101);
    repeat (4) @(posedge clk);
    #1 check("scan_2", ssd_ctrl, 3'b011);
    repeat (4) @(posedge clk);
    #1 check("scan_wrap", ssd_ctrl, 3'b110);

    num(4); num(7); key(K_PLUS); num(2); num(5);
    enter_timed("add47_25");
    check("add47_25_state", state, 2'd3);
    check("add47_25_disp", disp_bcd, 12'h072);
    check("add47_25_neg", disp_neg, 1'b0);

    num(9); num(9); key(K_PLUS); num(9); num(9); key(K_ENTER);
    repeat (2) @(posedge clk); #1;
    check("add99_99", disp_bcd, 12'h198);

    num(0); num(0); key(K_PLUS); num(0); num(0); key(K_ENTER);
    repeat (2) @(posedge clk); #1;
    check("add00_00", disp_bcd, 12'h000);

    num(1); num(2); key(K_MINUS); num(4); num(5); key(K_ENTER);
    repeat (2) @(posedge clk); #1;
    check("sub12_45", disp_bcd, 12'h033);
    check("sub12_45_neg", disp_neg, 1'b1);
    wait_scan(3'b011, "minus_idx2");
    check("minus_sign", scan_digit, 4'hA);

    num(4); num(5); key(K_MINUS); num(1); num(2); key(K_ENTER);
    repeat (2) @(posedge clk); #1;
    check("sub45_12", disp_bcd, 12'h033);
    check("sub45_12_neg", disp_neg, 1'b0);

    num(1); num(2); num(3);
    check("full_a", disp_bcd, 12'h012);
    key(K_ESC);
    check("esc_a", disp_bcd, 12'h000);
    press(digit_code(7), 50);
    check("held_7", disp_bcd, 12'h007);
    key(9'h01C);
    check("ignored_1c", disp_bcd, 12'h007);

    key(K_MINUS); num(4);
    check("b_entry", disp_bcd, 12'h004);
    check("b_op_sub", op_sub, 1'b1);
    key(K_ESC);
    check("esc_b_state", state, 2'd0);
    check("esc_b_disp", disp_bcd, 12'h000);
    check("esc_b_op", op_sub, 1'b0);

    num(1); key(K_PLUS); num(2);
    @(posedge clk); #1;
    last_change = K_ENTER;
    key_press = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 check("rst_calc_state", state, 2'd0);
    check("rst_calc_rv", result_valid, 1'b0);
    key_press = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);

`ifdef LEADING_BLANK_EN
    num(5);
    wait_scan(3'b011, "blank_idx2");
    check("blank_2", scan_digit, 4'hF);
    wait_scan(3'b110, "blank_idx0");
    check("blank_0", scan_digit, 4'h5);
    wait_scan(3'b101, "blank_idx1");
    check("blank_1", scan_digit, 4'hF);
`endif

    repeat (4) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/kbd_bcd_calc.md
Name: kbd_bcd_calc

Overview:
- Parametrised keyboard calculator core: takes decoded PS/2 key codes and enters two DIGITS-wide BCD operands.
- Computes A+B or A−B digit-serially and presents the operand or result as a BCD vector with a multiplexed single-digit scan output.
- Sits between the keyboard decoder and the 7-segment decoder, replacing the fixed 1-digit add path.

Parameters:
DIGITS, 2, BCD digits per operand; result and display are DIGITS+1 digits wide.
REFRESH_DIV, 100000, clk cycles per display scan step (minimum 1).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
last_change  input  9  most recent make code from the keyboard decoder (bit 8 = extended)
key_press  input  1  level: high while the key in last_change is held
state  output  2  0=ENTER_A, 1=ENTER_B, 2=CALC, 3=SHOW
op_sub  output  1  latched operator: 0 = add, 1 = subtract
result_valid  output  1  one-cycle pulse when the result is written
disp_bcd  output  4*(DIGITS+1)  BCD value currently displayed, digit 0 = LS nibble
disp_neg  output  1  displayed result is negative
scan_digit  output  4  nibble for the currently scanned position; 4'hA = minus, 4'hF = blank
ssd_ctrl  output  DIGITS+1  active-low one-hot digit enable

Behaviour:
- Reset (reset==0 at clk edge): state=ENTER_A, A=B=R=0, op_sub=0, result_valid=0, disp_neg=0, scan index=0, ssd_ctrl=~1, divider=0. This applies in every state, including mid-CALC.
- Key event: a rising edge of key_press, detected with a registered copy. Exactly one event per press; holding the key produces no repeats. Events are acted on in the cycle they are detected.
- Key map: digit codes 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 = 0..9. '+' = 0x79. '-' = 0x7B. Enter = 0x5A. Esc = 0x76. All other codes are ignored.
- ENTER_A:
  - Digit: A = {A shifted left one nibble, d}, only if fewer than DIGITS digits have been entered; otherwise the digit is ignored (no wrap).
  - '+'/'-': latch op_sub, go to ENTER_B.
  - Enter: ignored.
- ENTER_B:
  - Digit: shifts into B under the same rule as A.
  - Enter: go to CALC.
  - '+'/'-': re-latch op_sub.
- CALC:
  - Cycle 0: compare A and B. For subtract with A<B, set neg and swap operands.
  - Cycles 1..DIGITS: one BCD digit per cycle, LS first, with carry/borrow. Add correction: +6 when the digit sum exceeds 9.
  - Final carry goes into digit DIGITS. For subtract, digit DIGITS = 0.
  - The next edge enters SHOW with result_valid=1 for one cycle. Latency from the Enter edge to result_valid is DIGITS+1 cycles.
  - All keys except Esc are ignored.
- SHOW:
  - Digit: clears A, B and neg, A = d, go to ENTER_A.
  - '+'/'-'/Enter: ignored.
- Esc, in any state: same effect as reset except the scan state.
- disp_bcd:
  - ENTER_A: zero-extended A.
  - ENTER_B: zero-extended B.
  - CALC: holds the previous display.
  - SHOW: R.
- disp_neg: equals neg only in SHOW.
- Scan:
  - The divider counts 0..REFRESH_DIV−1. At wrap, the index advances 0..DIGITS and then wraps to 0.
  - ssd_ctrl = ~(1<<index). scan_digit = disp_bcd nibble[index].
  - If disp_neg and index==DIGITS, scan_digit = 4'hA.

Optional Feature:
- LEADING_BLANK_EN defined: scan_digit = 4'hF for any position above the most significant non-zero displayed digit. Position 0 is never blanked. The minus sign overrides blanking.
- Undefined: every position shows its BCD nibble, including leading zeros.

Test Plan:
- DIGITS=2, REFRESH_DIV=4. Reset held 2 cycles -> state=0, disp_bcd=12'h000, ssd_ctrl=3'b110, result_valid=0; scan cycles 110→101→011 every 4 clks.
- Keys 4,7,+,2,5,Enter -> result_valid 3 cycles after the Enter edge, state=3, disp_bcd=12'h072, disp_neg=0.
- Keys 9,9,+,9,9,Enter -> disp_bcd=12'h198; 0,0,+,0,0,Enter -> 12'h000.
- Keys 1,2,-,4,5,Enter -> disp_bcd=12'h033, disp_neg=1, scan_digit=4'hA at index 2. Then 4,5,-,1,2,Enter -> 12'h033, disp_neg=0.
- Keys 1,2,3 -> disp_bcd=12'h012. Key '7' held 50 cycles -> one digit shifted in. Code 0x1C -> no change.
- Esc during ENTER_B -> state=0, disp 0. Reset asserted in CALC cycle 1 -> state=0, no result_valid. With LEADING_BLANK_EN: A=5 -> scan_digit F,F,5 for index 2,1,0.
